// File: rtl/dtree_vote_collector.sv
// Majority-vote collector for a decision-tree classifier.
// Collects WINDOW in-range labels into one counter per class, then scans the
// counters one per cycle and presents the winning label with its count.
// Out-of-range labels are consumed but only bump a saturating error counter.
module dtree_vote_collector #(
    parameter int unsigned CLASS_W     = 4,
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned WINDOW      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CLASS_W-1:0]           class_in,
    input  logic                         class_valid,
    output logic                         class_ready,
    output logic [CLASS_W-1:0]           vote_class,
    output logic [$clog2(WINDOW+1)-1:0]  vote_count,
    output logic                         vote_valid,
    input  logic                         vote_ready,
    output logic [7:0]                   err_cnt
);

    localparam int unsigned CNT_W = $clog2(WINDOW + 1);
    localparam int unsigned IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CLASSES];
    logic [CNT_W-1:0]   cnt_d [NUM_CLASSES];
    logic [CNT_W-1:0]   win_q, win_d;
    logic [7:0]         err_q, err_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CLASS_W-1:0] best_cls_q, best_cls_d;
    logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
    logic [CLASS_W-1:0] vote_class_q, vote_class_d;
    logic [CNT_W-1:0]   vote_count_q, vote_count_d;
    logic               vote_valid_q, vote_valid_d;

    logic               accept;
    logic               in_range;
    logic [CNT_W-1:0]   scan_val;

    assign class_ready = (state_q == ST_ACCUM);
    assign vote_class  = vote_class_q;
    assign vote_count  = vote_count_q;
    assign vote_valid  = vote_valid_q;
    assign err_cnt     = err_q;

    // Handshake qualification and selection of the counter under scan
    always_comb begin
        accept   = class_valid && (state_q == ST_ACCUM);
        in_range = (32'(class_in) < NUM_CLASSES);
        scan_val = '0;
        for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
            if (32'(idx_q) == i) scan_val = cnt_q[i];
        end
    end

    // Next-state logic for the accumulate / scan / output sequence
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        win_d        = win_q;
        err_d        = err_q;
        idx_d        = idx_q;
        best_cls_d   = best_cls_q;
        best_cnt_d   = best_cnt_q;
        vote_class_d = vote_class_q;
        vote_count_d = vote_count_q;
        vote_valid_d = vote_valid_q;

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (in_range) begin
                        for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                            if (32'(class_in) == i) cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                        win_d = win_q + 1'b1;
                        if (32'(win_q) == WINDOW - 1) state_d = ST_SCAN;
                    end else if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
            end
            ST_SCAN: begin
                // Strict compare keeps the earliest (lowest) index on ties
                if (scan_val > best_cnt_q) begin
                    best_cnt_d = scan_val;
                    best_cls_d = CLASS_W'(idx_q);
                end
                if (32'(idx_q) == NUM_CLASSES - 1) begin
                    idx_d   = '0;
                    state_d = ST_OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_OUT: begin
                // First OUT cycle registers the result; vote_ready only matters once it is shown
                if (!vote_valid_q) begin
                    vote_valid_d = 1'b1;
                    vote_class_d = best_cls_q;
                    vote_count_d = best_cnt_q;
                end else if (vote_ready) begin
                    vote_valid_d = 1'b0;
                    for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt_d[i] = '0;
                    win_d      = '0;
                    best_cls_d = '0;
                    best_cnt_d = '0;
                    state_d    = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
            win_q        <= '0;
            err_q        <= '0;
            idx_q        <= '0;
            best_cls_q   <= '0;
            best_cnt_q   <= '0;
            vote_class_q <= '0;
            vote_count_q <= '0;
            vote_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= cnt_d[i];
            win_q        <= win_d;
            err_q        <= err_d;
            idx_q        <= idx_d;
            best_cls_q   <= best_cls_d;
            best_cnt_q   <= best_cnt_d;
            vote_class_q <= vote_class_d;
            vote_count_q <= vote_count_d;
            vote_valid_q <= vote_valid_d;
        end
    end

endmodule

// File: tb/tb_dtree_vote_collector.sv
// Self-checking bench for dtree_vote_collector (default parameters).
module tb_dtree_vote_collector;

    logic       clk;
    logic       rst_n;
    logic [3:0] class_in;
    logic       class_valid;
    logic       class_ready;
    logic [3:0] vote_class;
    logic [3:0] vote_count;
    logic       vote_valid;
    logic       vote_ready;
    logic [7:0] err_cnt;

    dtree_vote_collector #(
        .CLASS_W(4),
        .NUM_CLASSES(10),
        .WINDOW(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .class_in(class_in),
        .class_valid(class_valid),
        .class_ready(class_ready),
        .vote_class(vote_class),
        .vote_count(vote_count),
        .vote_valid(vote_valid),
        .vote_ready(vote_ready),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] cls;
        logic [3:0] cnt;
    } exp_t;

    typedef struct {
        logic [3:0] lab [8];
        logic [3:0] ecls;
        logic [3:0] ecnt;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];

    int checks   = 0;
    int errors   = 0;
    int last_acc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_label(input logic [3:0] v);
        class_in    = v;
        class_valid = 1'b1;
        @(posedge clk);
        #1;
        class_valid = 1'b0;
        last_acc    = cyc;
    endtask

    // Wait (bounded) for the vote, then compare against the scoreboard head
    task automatic wait_and_check(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!vote_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!vote_valid) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_latency"}, cyc - last_acc, 11);
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_vote"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_class"}, vote_class, e.cls);
        chk({tag, "_count"}, vote_count, e.cnt);
        chk({tag, "_ready_low_in_out"}, class_ready, 0);
    endtask

    task automatic handshake(input string tag);
        vote_ready = 1'b1;
        @(posedge clk);
        #1;
        vote_ready  = 1'b0;
        class_valid = 1'b0;
        chk({tag, "_valid_drop"}, vote_valid, 0);
        chk({tag, "_ready_back"}, class_ready, 1);
    endtask

    // Async pulse between edges; outputs must clear while rst_n is low
    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_rst_valid"}, vote_valid, 0);
        chk({tag, "_rst_class"}, vote_class, 0);
        chk({tag, "_rst_count"}, vote_count, 0);
        chk({tag, "_rst_err"}, err_cnt, 0);
        chk({tag, "_rst_ready"}, class_ready, 1);
        #2 rst_n = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] seq [10];
        logic       ok;
        int         err_exp;
        logic [3:0] vc;
        logic [3:0] vn;

        vecs[0].lab = '{4'd3, 4'd3, 4'd5, 4'd3, 4'd7, 4'd3, 4'd5, 4'd1};
        vecs[0].ecls = 4'd3; vecs[0].ecnt = 4'd4;
        vecs[1].lab = '{4'd6, 4'd2, 4'd6, 4'd2, 4'd6, 4'd2, 4'd6, 4'd2};
        vecs[1].ecls = 4'd2; vecs[1].ecnt = 4'd4;
        vecs[2].lab = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        vecs[2].ecls = 4'd9; vecs[2].ecnt = 4'd8;
        vecs[3].lab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        vecs[3].ecls = 4'd0; vecs[3].ecnt = 4'd1;
        vecs[4].lab = '{4'd8, 4'd8, 4'd8, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
        vecs[4].ecls = 4'd1; vecs[4].ecnt = 4'd3;

        rst_n       = 1'b0;
        class_in    = '0;
        class_valid = 1'b0;
        vote_ready  = 1'b0;
        err_exp     = 0;
        #23 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_ready", class_ready, 1);
        chk("reset_valid", vote_valid, 0);
        chk("reset_class", vote_class, 0);
        chk("reset_count", vote_count, 0);
        chk("reset_err", err_cnt, 0);

        // Table-driven windows
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 8; k++) send_label(vecs[v].lab[k]);
            sb.push_back('{cls: vecs[v].ecls, cnt: vecs[v].ecnt});
            wait_and_check($sformatf("vec%0d", v));
            handshake($sformatf("vec%0d", v));
        end

        // Out-of-range labels interleaved with in-range ones
        seq = '{4'd3, 4'd12, 4'd3, 4'd15, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
        for (int k = 0; k < 9; k++) send_label(seq[k]);
        err_exp += 2;
        chk("oor_err_cnt", err_cnt, err_exp);
        chk("oor_window_open", class_ready, 1);
        chk("oor_no_vote", vote_valid, 0);
        send_label(seq[9]);
        sb.push_back('{cls: 4'd4, cnt: 4'd6});
        wait_and_check("oor");
        handshake("oor");

        // Stall in OUT with labels offered
        for (int k = 0; k < 8; k++) send_label((k < 3) ? 4'd1 : 4'd7);
        sb.push_back('{cls: 4'd7, cnt: 4'd5});
        wait_and_check("stall");
        vc = vote_class;
        vn = vote_count;
        ok = 1'b1;
        class_in    = 4'd5;
        class_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (!vote_valid || vote_class != vc || vote_count != vn || class_ready) ok = 1'b0;
        end
        chk("stall_stable", ok, 1);
        chk("stall_err_unchanged", err_cnt, err_exp);
        handshake("stall");
        for (int k = 0; k < 8; k++) send_label(4'd5);
        sb.push_back('{cls: 4'd5, cnt: 4'd8});
        wait_and_check("post_stall");
        handshake("post_stall");

        // Reset mid-window
        for (int k = 0; k < 5; k++) send_label(4'd7);
        pulse_reset("midwin");
        err_exp = 0;
        seq = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd7, 4'd7, 4'd7, 4'd0, 4'd0};
        for (int k = 0; k < 8; k++) send_label(seq[k]);
        sb.push_back('{cls: 4'd2, cnt: 4'd5});
        wait_and_check("after_midwin");
        handshake("after_midwin");

        // Reset during SCAN
        for (int k = 0; k < 8; k++) send_label(4'd6);
        repeat (3) @(posedge clk);
        #1;
        pulse_reset("midscan");
        ok = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (vote_valid) ok = 1'b1;
        end
        chk("midscan_no_stale_vote", ok, 0);
        seq = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        for (int k = 0; k < 8; k++) send_label(seq[k]);
        sb.push_back('{cls: 4'd0, cnt: 4'd4});
        wait_and_check("after_midscan");
        handshake("after_midscan");

        // Reset while a vote is pending in OUT
        for (int k = 0; k < 8; k++) send_label(4'd9);
        sb.push_back('{cls: 4'd9, cnt: 4'd8});
        wait_and_check("out_rst");
        pulse_reset("inout");
        chk("inout_after_valid", vote_valid, 0);

        // Error counter saturation with 300 out-of-range labels
        ok = 1'b1;
        for (int k = 0; k < 300; k++) begin
            send_label(4'd11);
            if (k < 255) err_exp++;
            if (vote_valid || !class_ready) ok = 1'b0;
            if (k == 253) chk("sat_err_254", err_cnt, 254);
        end
        chk("sat_err_255", err_cnt, err_exp);
        chk("sat_no_vote", ok, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/dtree_vote_collector.md
DTREE_VOTE_COLLECTOR -- requirements
Module: dtree_vote_collector

Interface
REQ-001 SHALL have parameter CLASS_W, default 4, meaning width of the class label input.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, meaning number of valid labels (0..NUM_CLASSES-1).
REQ-003 SHALL have parameter WINDOW, default 8, meaning number of valid labels per vote (WINDOW >= 1).
REQ-004 SHALL have port clk, input, 1, meaning single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous, active-low reset.
REQ-006 SHALL have port class_in, input, CLASS_W, meaning label produced by the tree classifier.
REQ-007 SHALL have port class_valid, input, 1, meaning class_in is valid this cycle.
REQ-008 SHALL have port class_ready, output, 1, meaning the block accepts a label this cycle.
REQ-009 SHALL have port vote_class, output, CLASS_W, meaning majority label of the completed window.
REQ-010 SHALL have port vote_count, output, clog2(WINDOW+1), meaning number of occurrences of vote_class in the window.
REQ-011 SHALL have port vote_valid, output, 1, meaning vote_class and vote_count are valid.
REQ-012 SHALL have port vote_ready, input, 1, meaning the downstream consumer takes the vote.
REQ-013 SHALL have port err_cnt, output, 8, meaning saturating count of out-of-range labels since reset.

Function
REQ-014 SHALL implement three states: ACCUM, SCAN and OUT.
REQ-015 SHALL treat a label as accepted in a cycle only when class_valid and class_ready are both 1.
REQ-016 SHALL drive class_ready = 1 in ACCUM and 0 in SCAN and OUT.
REQ-017 SHALL, for an accepted label < NUM_CLASSES, increment that label's counter and the window counter by 1.
REQ-018 SHALL, for an accepted label >= NUM_CLASSES, leave all class counters and the window counter unchanged and increment err_cnt, saturating at 255.
REQ-019 SHALL size each class counter and the window counter to clog2(WINDOW+1) bits; no counter exceeds WINDOW.
REQ-020 SHALL move from ACCUM to SCAN on the edge that accepts the WINDOW-th in-range label.
REQ-021 SHALL, in SCAN, examine one class counter per cycle from index 0 to NUM_CLASSES-1, taking exactly NUM_CLASSES cycles.
REQ-022 SHALL replace the running best only when a counter is strictly greater, so ties resolve to the lowest index.
REQ-023 SHALL move from SCAN to OUT after index NUM_CLASSES-1; if the last label is accepted at edge t, vote_valid rises at edge t+NUM_CLASSES+1.
REQ-024 SHALL, in OUT, hold vote_valid=1 with vote_class and vote_count stable until vote_ready=1.
REQ-025 SHALL, on the OUT edge with vote_ready=1, clear all class counters, the window counter and the running best, deassert vote_valid and return to ACCUM.
REQ-026 SHALL keep class_ready=0 during the handshake edge, so the first label of the next window can be accepted no earlier than the following cycle.
REQ-027 SHALL drive vote_valid=0 outside OUT; vote_class and vote_count SHALL hold their last values outside OUT.
REQ-028 SHALL ignore vote_ready outside OUT and ignore class_valid outside ACCUM.
REQ-029 SHALL let err_cnt count across windows; err_cnt is cleared only by reset.

Reset
REQ-030 SHALL, while rst_n=0 and regardless of clk, force state=ACCUM, all counters=0, err_cnt=0, vote_class=0, vote_count=0 and vote_valid=0.
REQ-031 SHALL drive class_ready=1 on the first cycle after rst_n deasserts.
REQ-032 SHALL, on reset asserted mid-window, mid-SCAN or in OUT, discard the partial window and any pending vote; no vote from before reset is ever presented.

Verification
REQ-033 SHALL cover this scenario: labels 3,3,5,3,7,3,5,1 are sent back-to-back -> vote_class=3, vote_count=4, with vote_valid rising 11 cycles after the 8th accept.
REQ-034 SHALL cover this scenario: labels 6,2,6,2,6,2,6,2 are sent -> vote_class=2, vote_count=4 (tie resolves to the lower index).
REQ-035 SHALL cover this scenario: labels 12,15 are inserted among 8 in-range labels -> err_cnt=2, the window closes only after 8 in-range labels, and counts exclude 12 and 15.
REQ-036 SHALL cover this scenario: vote_ready is held 0 for 20 cycles in OUT with class_valid=1 -> outputs stay stable, class_ready=0, no labels are accepted; when vote_ready=1, counters clear and class_ready=1 on the next cycle.
REQ-037 SHALL cover this scenario: rst_n is pulsed low asynchronously after 5 accepts, and again during SCAN -> all outputs are 0 immediately, and the next 8 labels produce a vote counted from zero.
REQ-038 SHALL cover this scenario: 300 labels of value 11 are sent -> err_cnt saturates at 255 and no vote is produced.
